conv_mac_engine: RTL and testbench
==================================

// Module: conv_mac_engine
// PURPOSE
//  Consumer stage of the double-buffered input memories. When inputs_loaded=1, reads the X (R x C) and W (K x K) matrices through their read ports.
//  Computes the valid 2D convolution Y[r][c] = B + sum_{i,j<K} X[r+i][c+j]*W[i*K+j] over (R-K+1) x (C-K+1) outputs, in row-major order.
//  Streams the outputs out on an AXI-Stream master, then pulses compute_finished so the memories swap buffers.
// PARAMETERS
//  INW   24  bit width of X, W and B words (signed)
//  R     9   rows of X
//  C     8   columns of X
//  MAXK  4   largest supported K; K_BITS=$clog2(MAXK+1), X_ADDR_BITS=$clog2(R*C), W_ADDR_BITS=$clog2(MAXK*MAXK)
//  OUTW  2*INW+$clog2(MAXK*MAXK)  output/accumulator width (signed, no truncation)
// PORTS
//  clk              in   1            single clock, rising edge
//  reset            in   1            asynchronous, active-low reset
//  inputs_loaded    in   1            memories hold a complete X/W/K/B set
//  K                in   K_BITS       weight size; valid 2..MAXK while inputs_loaded=1
//  B                in   INW          signed bias
//  X_read_addr      out  X_ADDR_BITS  X read address; data returns 1 cycle later
//  X_data           in   INW          signed X word
//  W_read_addr      out  W_ADDR_BITS  W read address; data returns 1 cycle later
//  W_data           in   INW          signed W word
//  compute_finished out  1            1-cycle pulse after the last output is accepted
//  AXIS_OUT_TDATA   out  OUTW         signed result Y
//  AXIS_OUT_TVALID  out  1            result valid
//  AXIS_OUT_TREADY  in   1            downstream ready
// BEHAVIOUR
//  Reset (reset=0): state=IDLE; all outputs 0; counters r,c,i,j and accumulator cleared. Takes effect immediately, including mid-frame.
//  FSM states: IDLE, MAC, FLUSH, OUT, DONE.
//  - IDLE: if inputs_loaded=1, latch K->k_q and B->b_q, clear r,c,i,j, then go to MAC.
//  - MAC: each cycle issue X addr (r+i)*C+(c+j) and W addr i*K+j; j increments, wrapping at k_q-1 with i+1. Go to FLUSH after issuing i=j=k_q-1.
//  - Pipeline: addr (t) -> mem data (t+1) -> registered signed product, 2*INW bits (t+2) -> acc += sext(product) (t+3).
//  - acc is preloaded with sext(b_q) at the first tap of each output.
//  - FLUSH: wait 2 cycles for the pipeline to drain, load the output register, then go to OUT.
//  - OUT: TVALID=1 with TDATA stable until TVALID&TREADY. On handshake, advance c, wrapping at C-k_q with r+1.
//    Return to MAC for the next output, or go to DONE after r=R-k_q, c=C-k_q.
//  - DONE: compute_finished=1 for exactly one cycle, then go to IDLE. A new frame starts on the next cycle if inputs_loaded is still 1.
//  Latency: first TVALID 3+K*K cycles after leaving IDLE. Throughput is one output per K*K+3 cycles, plus any backpressure stall.
//  TVALID never drops without a handshake; TREADY held low stalls in OUT indefinitely, with no address activity.
//  TREADY=1 while TVALID=0 has no effect.
//  k_q and b_q are held for the whole frame; K/B changes on the inputs mid-frame are ignored.
//  Boundary cases:
//  - K=MAXK=4 gives 6x5=30 outputs. K=2 gives 8x7=56 outputs.
//  - K=R or K=C yields a single output row or column.
//  - K<2 while inputs_loaded=1 is treated as K=2.
//  - inputs_loaded dropping mid-frame does not abort the frame.
//  Arithmetic: all signed, two's complement. The OUTW accumulator cannot overflow for K<=MAXK.
// CONFIGURATION
//  CONV_RELU_EN defined: the output register loads max(acc,0); negative results are emitted as 0.
//  Undefined: the raw signed accumulator is emitted. All timing is identical either way.
// STRUCTURE
//  conv_pkg holds:
//  - the typedef enum conv_state_t {IDLE,MAC,FLUSH,OUT,DONE};
//  - the localparams K_BITS/X_ADDR_BITS/W_ADDR_BITS/OUTW functions, shared with input_mems.
//  Sub-module conv_addr_gen holds the r/c/i/j counters and the address arithmetic.
//  It takes step/next_out/start inputs and produces last_tap/last_out flags. MAC, pipeline and FSM stay in the top module.
// TESTING
//  1. K=2, B=5, X[a]=a, W={1,0,0,1} -> Y[0][0]=5+0+9=14, 56 outputs, then one compute_finished pulse.
//  2. K=4, B=0, all X=1, all W=-1 -> 30 outputs of -16, or 0 with CONV_RELU_EN.
//  3. K=3, TREADY toggled randomly -> TDATA stable while stalled, exactly 42 handshakes, results match the reference model.
//  4. Extremes: X=W=-(2^23), K=4, B=-(2^23) -> Y=16*2^46-2^23, no overflow.
//  5. Reset asserted mid-MAC and mid-OUT -> outputs 0 immediately; after release with inputs_loaded=1 the frame restarts from Y[0][0].
//  6. inputs_loaded held high across two frames with K changed 3->2 between them -> 42 then 56 outputs, two compute_finished pulses.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution MAC engine and the input memories.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MAC,
        FLUSH,
        OUT,
        DONE
    } conv_state_t;

    function automatic int k_bits(input int max_k);
        return $clog2(max_k + 1);
    endfunction

    function automatic int x_addr_bits(input int rows, input int cols);
        return $clog2(rows * cols);
    endfunction

    function automatic int w_addr_bits(input int max_k);
        return $clog2(max_k * max_k);
    endfunction

    // Accumulator width: full product plus growth for MAXK*MAXK taps.
    function automatic int outw(input int in_w, input int max_k);
        return 2 * in_w + $clog2(max_k * max_k);
    endfunction

endpackage

// File: rtl/conv_mac_engine_if.sv
// AXI-Stream result port of the convolution MAC engine.
interface conv_mac_engine_if #(
    parameter int OUTW = conv_pkg::outw(24, 4)
);
    logic signed [OUTW-1:0] AXIS_OUT_TDATA;
    logic                   AXIS_OUT_TVALID;
    logic                   AXIS_OUT_TREADY;

    modport master (
        output AXIS_OUT_TDATA,
        output AXIS_OUT_TVALID,
        input  AXIS_OUT_TREADY
    );

    modport slave (
        input  AXIS_OUT_TDATA,
        input  AXIS_OUT_TVALID,
        output AXIS_OUT_TREADY
    );
endinterface

// File: rtl/conv_addr_gen.sv
// Output (r,c) and tap (i,j) counters of the convolution engine, with X/W read address arithmetic.
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int  R    = 9,
    parameter int  C    = 8,
    parameter int  MAXK = 4,
    localparam int K_BITS = k_bits(MAXK),
    localparam int XA     = x_addr_bits(R, C),
    localparam int WA     = w_addr_bits(MAXK)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step,
    input  logic              next_out,
    input  logic [K_BITS-1:0] k,
    output logic [XA-1:0]     x_addr,
    output logic [WA-1:0]     w_addr,
    output logic              first_tap,
    output logic              last_tap,
    output logic              last_out
);

    localparam logic [XA-1:0] ONE = XA'(1);

    logic [XA-1:0] r_q, r_d, c_q, c_d, i_q, i_d, j_q, j_d;
    logic [XA-1:0] kx;

    assign kx = XA'(k);

    always_comb begin
        r_d = r_q;
        c_d = c_q;
        i_d = i_q;
        j_d = j_q;
        if (start) begin
            r_d = '0;
            c_d = '0;
            i_d = '0;
            j_d = '0;
        end else begin
            // Taps wrap back to (0,0) after the last one, ready for the next output.
            if (step) begin
                if (j_q == kx - ONE) begin
                    j_d = '0;
                    i_d = (i_q == kx - ONE) ? '0 : i_q + ONE;
                end else begin
                    j_d = j_q + ONE;
                end
            end
            if (next_out) begin
                if (c_q == XA'(C) - kx) begin
                    c_d = '0;
                    r_d = r_q + ONE;
                end else begin
                    c_d = c_q + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
            c_q <= '0;
            i_q <= '0;
            j_q <= '0;
        end else begin
            r_q <= r_d;
            c_q <= c_d;
            i_q <= i_d;
            j_q <= j_d;
        end
    end

    assign x_addr    = (r_q + i_q) * XA'(C) + (c_q + j_q);
    assign w_addr    = WA'(i_q * kx + j_q);
    assign first_tap = (i_q == '0) && (j_q == '0);
    assign last_tap  = (i_q == kx - ONE) && (j_q == kx - ONE);
    assign last_out  = (r_q == XA'(R) - kx) && (c_q == XA'(C) - kx);

endmodule

// File: rtl/conv_mac_engine.sv
// Valid 2D convolution of X (R x C) with W (K x K) plus bias, streamed out over AXI-Stream.
// Optional CONV_RELU_EN: outputs are clamped at zero (max(acc,0)); timing is unchanged.
//
//  state | meaning
//  IDLE  | waiting for inputs_loaded; latches K and B
//  MAC   | issuing one X/W read pair per tap
//  FLUSH | two cycles draining the read/multiply pipeline, then loads the output register
//  OUT   | TVALID held with stable TDATA until the handshake
//  DONE  | one-cycle compute_finished pulse
module conv_mac_engine
    import conv_pkg::*;
#(
    parameter int  INW  = 24,
    parameter int  R    = 9,
    parameter int  C    = 8,
    parameter int  MAXK = 4,
    localparam int K_BITS      = k_bits(MAXK),
    localparam int X_ADDR_BITS = x_addr_bits(R, C),
    localparam int W_ADDR_BITS = w_addr_bits(MAXK),
    localparam int OUTW        = outw(INW, MAXK)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   inputs_loaded,
    input  logic [K_BITS-1:0]      K,
    input  logic signed [INW-1:0]  B,
    output logic [X_ADDR_BITS-1:0] X_read_addr,
    input  logic signed [INW-1:0]  X_data,
    output logic [W_ADDR_BITS-1:0] W_read_addr,
    input  logic signed [INW-1:0]  W_data,
    output logic                   compute_finished,
    conv_mac_engine_if.master      axis_out
);

    conv_state_t              state_q, state_d;
    logic [K_BITS-1:0]        k_q, k_d;
    logic signed [INW-1:0]    b_q, b_d;
    logic                     flush_q, flush_d;
    logic                     v1_q, v1_d, f1_q, f1_d, v2_q, v2_d, f2_q, f2_d;
    logic signed [2*INW-1:0]  prod_q, prod_d;
    logic signed [OUTW-1:0]   acc_q, acc_d;
    logic signed [OUTW-1:0]   out_q, out_d;

    logic                     start, step, next_out;
    logic                     first_tap, last_tap, last_out;
    logic [X_ADDR_BITS-1:0]   x_addr;
    logic [W_ADDR_BITS-1:0]   w_addr;

    conv_addr_gen #(
        .R    (R),
        .C    (C),
        .MAXK (MAXK)
    ) u_addr_gen (
        .clk       (clk),
        .rst_n     (reset),
        .start     (start),
        .step      (step),
        .next_out  (next_out),
        .k         (k_q),
        .x_addr    (x_addr),
        .w_addr    (w_addr),
        .first_tap (first_tap),
        .last_tap  (last_tap),
        .last_out  (last_out)
    );

    // Tap valid/first flags follow the read data (stage 1) and the product (stage 2).
    always_comb begin
        v1_d   = (state_q == MAC);
        f1_d   = (state_q == MAC) && first_tap;
        v2_d   = v1_q;
        f2_d   = f1_q;
        prod_d = X_data * W_data;
        acc_d  = acc_q;
        if (v2_q) begin
            acc_d = (f2_q ? OUTW'(b_q) : acc_q) + OUTW'(prod_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        b_d      = b_q;
        flush_d  = flush_q;
        out_d    = out_q;
        start    = 1'b0;
        step     = 1'b0;
        next_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (inputs_loaded) begin
                    if (K < K_BITS'(2)) begin
                        k_d = K_BITS'(2);
                    end else if (K > K_BITS'(MAXK)) begin
                        k_d = K_BITS'(MAXK);
                    end else begin
                        k_d = K;
                    end
                    b_d     = B;
                    start   = 1'b1;
                    state_d = MAC;
                end
            end
            MAC: begin
                step = 1'b1;
                if (last_tap) begin
                    flush_d = 1'b0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // The last product is summed this cycle, so load straight from acc_d.
                if (flush_q) begin
`ifdef CONV_RELU_EN
                    out_d = acc_d[OUTW-1] ? '0 : acc_d;
`else
                    out_d = acc_d;
`endif
                    state_d = OUT;
                end else begin
                    flush_d = 1'b1;
                end
            end
            OUT: begin
                if (axis_out.AXIS_OUT_TREADY) begin
                    if (last_out) begin
                        state_d = DONE;
                    end else begin
                        next_out = 1'b1;
                        state_d  = MAC;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            b_q     <= '0;
            flush_q <= 1'b0;
            v1_q    <= 1'b0;
            f1_q    <= 1'b0;
            v2_q    <= 1'b0;
            f2_q    <= 1'b0;
            prod_q  <= '0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            b_q     <= b_d;
            flush_q <= flush_d;
            v1_q    <= v1_d;
            f1_q    <= f1_d;
            v2_q    <= v2_d;
            f2_q    <= f2_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    assign X_read_addr              = (state_q == MAC) ? x_addr : '0;
    assign W_read_addr              = (state_q == MAC) ? w_addr : '0;
    assign compute_finished         = (state_q == DONE);
    assign axis_out.AXIS_OUT_TVALID = (state_q == OUT);
    assign axis_out.AXIS_OUT_TDATA  = out_q;

endmodule

// File: tb/tb_conv_mac_engine.sv
// Self-checking bench for conv_mac_engine: frame table, reset/back-to-back sequences, reference model.
module tb_conv_mac_engine;
    import conv_pkg::*;

    localparam int INW  = 24;
    localparam int R    = 9;
    localparam int C    = 8;
    localparam int MAXK = 4;
    localparam int KB   = k_bits(MAXK);
    localparam int XA   = x_addr_bits(R, C);
    localparam int WA   = w_addr_bits(MAXK);
    localparam int OUTW = outw(INW, MAXK);
`ifdef CONV_RELU_EN
    localparam longint ALL_NEG_Y = 0;
`else
    localparam longint ALL_NEG_Y = -16;
`endif

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  inputs_loaded = 1'b0;
    logic [KB-1:0]         K = '0;
    logic signed [INW-1:0] B = '0;
    logic [XA-1:0]         X_read_addr;
    logic signed [INW-1:0] X_data = '0;
    logic [WA-1:0]         W_read_addr;
    logic signed [INW-1:0] W_data = '0;
    logic                  compute_finished;

    conv_mac_engine_if #(.OUTW(OUTW)) axis ();

    conv_mac_engine #(.INW(INW), .R(R), .C(C), .MAXK(MAXK)) dut (
        .clk              (clk),
        .reset            (reset),
        .inputs_loaded    (inputs_loaded),
        .K                (K),
        .B                (B),
        .X_read_addr      (X_read_addr),
        .X_data           (X_data),
        .W_read_addr      (W_read_addr),
        .W_data           (W_data),
        .compute_finished (compute_finished),
        .axis_out         (axis)
    );

    always #5 clk = ~clk;

    logic signed [INW-1:0] xmem [128];
    logic signed [INW-1:0] wmem [16];

    always @(posedge clk) begin
        X_data <= xmem[X_read_addr];
        W_data <= wmem[W_read_addr];
    end

    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;
    int     rdy_mode = 0;
    int     hs_count = 0;
    int     cf_count = 0;
    int     start_cyc = 0;
    int     hs_cyc[$];
    longint exp_q[$];
    longint first_seen = 0;
    bit     stall_prev = 1'b0;
    longint stall_data = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint rnd24();
        logic signed [INW-1:0] v;
        v = INW'($urandom);
        return longint'(v);
    endfunction

    // Reference: direct valid-convolution sums in row-major order.
    task automatic build_exp(input int k, input longint b);
        int kc;
        longint y;
        kc = (k < 2) ? 2 : k;
        for (int r = 0; r <= R - kc; r++) begin
            for (int c = 0; c <= C - kc; c++) begin
                y = b;
                for (int i = 0; i < kc; i++)
                    for (int j = 0; j < kc; j++)
                        y += longint'(xmem[(r + i) * C + c + j]) * longint'(wmem[i * kc + j]);
`ifdef CONV_RELU_EN
                if (y < 0) y = 0;
`endif
                exp_q.push_back(y);
            end
        end
    endtask

    task automatic fill(input int xm, input int wm);
        for (int a = 0; a < 128; a++) begin
            case (xm)
                0:       xmem[a] = INW'(a);
                1:       xmem[a] = INW'(1);
                2:       xmem[a] = INW'(-(64'sd1 <<< 23));
                default: xmem[a] = INW'($urandom);
            endcase
        end
        for (int a = 0; a < 16; a++) begin
            case (wm)
                0:       wmem[a] = (a == 0 || a == 3) ? INW'(1) : INW'(0);
                1:       wmem[a] = INW'(-1);
                2:       wmem[a] = INW'(-(64'sd1 <<< 23));
                default: wmem[a] = INW'($urandom);
            endcase
        end
    endtask

    task automatic wait_cf(input int target, input int budget);
        int t;
        t = 0;
        while (cf_count < target && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("frame_done_in_budget", longint'(cf_count >= target), 1);
    endtask

    task automatic clear_counts();
        hs_count = 0;
        cf_count = 0;
        hs_cyc.delete();
    endtask

    initial begin
        axis.AXIS_OUT_TREADY = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       axis.AXIS_OUT_TREADY = 1'b1;
                1:       axis.AXIS_OUT_TREADY = 1'($urandom_range(0, 1));
                default: axis.AXIS_OUT_TREADY = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            if (axis.AXIS_OUT_TVALID) begin
                if (stall_prev) chk("tdata_stable", axis.AXIS_OUT_TDATA, stall_data);
                if (axis.AXIS_OUT_TREADY) begin
                    if (hs_count == 0) first_seen = axis.AXIS_OUT_TDATA;
                    hs_cyc.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL extra_output: got %0d, expected no output", axis.AXIS_OUT_TDATA);
                    end else begin
                        chk("y", axis.AXIS_OUT_TDATA, exp_q.pop_front());
                    end
                    hs_count++;
                end
            end
            stall_prev = axis.AXIS_OUT_TVALID && !axis.AXIS_OUT_TREADY;
            stall_data = axis.AXIS_OUT_TDATA;
            if (compute_finished) cf_count++;
        end
    end

    typedef struct {
        int     k;
        longint b;
        int     xm;
        int     wm;
        int     rdy;
        int     n;
        bit     chk_first;
        longint first;
    } vec_t;

    vec_t tbl[6];

    initial begin
        longint b1, b2, exp_first;
        int kc;

        tbl[0] = '{2, 5, 0, 0, 0, 56, 1'b1, 14};
        tbl[1] = '{4, 0, 1, 1, 0, 30, 1'b1, ALL_NEG_Y};
        tbl[2] = '{3, rnd24(), 3, 3, 1, 42, 1'b0, 0};
        tbl[3] = '{4, -(64'sd1 <<< 23), 2, 2, 0, 30, 1'b1, (64'sd1 <<< 50) - (64'sd1 <<< 23)};
        tbl[4] = '{1, -3, 3, 3, 1, 56, 1'b0, 0};
        tbl[5] = '{4, rnd24(), 3, 3, 0, 30, 1'b0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", axis.AXIS_OUT_TVALID, 0);
        chk("rst_tdata", axis.AXIS_OUT_TDATA, 0);
        chk("rst_cf", compute_finished, 0);
        chk("rst_xaddr", X_read_addr, 0);
        chk("rst_waddr", W_read_addr, 0);
        reset = 1'b1;

        for (int n = 0; n < 6; n++) begin
            rdy_mode = tbl[n].rdy;
            fill(tbl[n].xm, tbl[n].wm);
            exp_q.delete();
            build_exp(tbl[n].k, tbl[n].b);
            clear_counts();
            @(posedge clk);
            #1;
            K = KB'(tbl[n].k);
            B = INW'(tbl[n].b);
            inputs_loaded = 1'b1;
            start_cyc = cyc;
            repeat (3) @(posedge clk);
            #1;
            inputs_loaded = 1'b0;
            K = KB'($urandom);
            B = INW'($urandom);
            wait_cf(1, 6000);
            repeat (5) @(posedge clk);
            #1;
            chk("handshakes", hs_count, tbl[n].n);
            chk("cf_pulses", cf_count, 1);
            chk("leftover", exp_q.size(), 0);
            if (tbl[n].chk_first) chk("first_y", first_seen, tbl[n].first);
            kc = (tbl[n].k < 2) ? 2 : tbl[n].k;
            if (tbl[n].rdy == 0 && hs_cyc.size() >= 2) begin
                chk("first_latency", hs_cyc[0] - start_cyc, kc * kc + 3);
                chk("out_interval", hs_cyc[1] - hs_cyc[0], kc * kc + 3);
            end
        end

        // Reset in the middle of MAC, then restart with inputs_loaded still high.
        rdy_mode = 0;
        fill(3, 3);
        exp_q.delete();
        clear_counts();
        @(posedge clk);
        #1;
        K = KB'(3);
        B = INW'(rnd24());
        inputs_loaded = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midmac_tvalid", axis.AXIS_OUT_TVALID, 0);
        chk("midmac_cf", compute_finished, 0);
        chk("midmac_xaddr", X_read_addr, 0);
        chk("midmac_waddr", W_read_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        build_exp(3, longint'(B));
        exp_first = exp_q[0];
        clear_counts();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        inputs_loaded = 1'b0;
        wait_cf(1, 3000);
        repeat (3) @(posedge clk);
        #1;
        chk("restart_y00", first_seen, exp_first);
        chk("restart_handshakes", hs_count, 42);
        chk("restart_leftover", exp_q.size(), 0);

        // Reset while stalled in OUT.
        rdy_mode = 2;
        fill(3, 3);
        exp_q.delete();
        clear_counts();
        @(posedge clk);
        #1;
        K = KB'(2);
        B = INW'(rnd24());
        inputs_loaded = 1'b1;
        for (int t = 0; t < 200 && !axis.AXIS_OUT_TVALID; t++) begin
            @(posedge clk);
            #1;
        end
        chk("reached_out", axis.AXIS_OUT_TVALID, 1);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midout_tvalid", axis.AXIS_OUT_TVALID, 0);
        chk("midout_tdata", axis.AXIS_OUT_TDATA, 0);
        chk("midout_cf", compute_finished, 0);
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        build_exp(2, longint'(B));
        exp_first = exp_q[0];
        clear_counts();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        inputs_loaded = 1'b0;
        wait_cf(1, 3000);
        repeat (3) @(posedge clk);
        #1;
        chk("restart2_y00", first_seen, exp_first);
        chk("restart2_handshakes", hs_count, 56);

        // Back-to-back frames; K/B changed mid-frame only apply to the second frame.
        rdy_mode = 1;
        fill(3, 3);
        exp_q.delete();
        b1 = rnd24();
        b2 = rnd24();
        build_exp(3, b1);
        build_exp(2, b2);
        clear_counts();
        @(posedge clk);
        #1;
        K = KB'(3);
        B = INW'(b1);
        inputs_loaded = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        K = KB'(2);
        B = INW'(b2);
        wait_cf(1, 4000);
        wait_cf(2, 6000);
        inputs_loaded = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("b2b_handshakes", hs_count, 98);
        chk("b2b_cf_pulses", cf_count, 2);
        chk("b2b_leftover", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
